// File: rtl/unbinning_2_pkg.sv
// Shared constants and geometry helpers for the mask binning/unbinning pair.
package unbinning_2_pkg;

    localparam int unsigned DEF_KERNEL_SIZE = 4;

    function automatic int unsigned bin_dim(input int unsigned res, input int unsigned kernel);
        return res / kernel;
    endfunction

    // One extra code above res so out-of-range counts stay representable.
    function automatic int unsigned count_width(input int unsigned res);
        return $clog2(res + 1);
    endfunction

    function automatic int unsigned addr_width(input int unsigned hres, input int unsigned vres,
                                               input int unsigned kernel);
        return $clog2(bin_dim(hres, kernel) * bin_dim(vres, kernel));
    endfunction

    typedef logic [addr_width(1280, 720, DEF_KERNEL_SIZE)-1:0] coarse_addr_t;

endpackage

// File: rtl/unbinning_2_if.sv
// Bus bundle for unbinning_2: coarse write port, full-res read request and aligned read result.
interface unbinning_2_if #(
    parameter int unsigned HWIDTH     = 11,
    parameter int unsigned VWIDTH     = 10,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned DATA_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   bin_pixel_in;
    logic [HWIDTH-SHIFT-1:0] bin_hcount_in;
    logic [VWIDTH-SHIFT-1:0] bin_vcount_in;
    logic                    bin_valid_in;
    logic [HWIDTH-1:0]       hcount_in;
    logic [VWIDTH-1:0]       vcount_in;
    logic                    read_valid_in;
    logic [DATA_WIDTH-1:0]   pixel_data_out;
    logic [HWIDTH-1:0]       hcount_out;
    logic [VWIDTH-1:0]       vcount_out;
    logic                    data_valid_out;
    logic                    frame_ready_out;

    modport master (
        output bin_pixel_in, bin_hcount_in, bin_vcount_in, bin_valid_in,
        output hcount_in, vcount_in, read_valid_in,
        input  pixel_data_out, hcount_out, vcount_out, data_valid_out, frame_ready_out
    );

    modport slave (
        input  bin_pixel_in, bin_hcount_in, bin_vcount_in, bin_valid_in,
        input  hcount_in, vcount_in, read_valid_in,
        output pixel_data_out, hcount_out, vcount_out, data_valid_out, frame_ready_out
    );
endinterface

// File: rtl/unbinning_2_addr_gen.sv
// Registered coarse (row, col) -> linear frame-buffer address with an in-range flag.
module unbin_addr_gen #(
    parameter int unsigned ROW_W  = 2,
    parameter int unsigned COL_W  = 3,
    parameter int unsigned BIN_H  = 4,
    parameter int unsigned BIN_V  = 2,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    output logic              valid_o,
    output logic              in_range_o,
    output logic [ADDR_W-1:0] addr_o
);
    logic              in_range_d;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        in_range_d = (32'(row_i) < BIN_V) && (32'(col_i) < BIN_H);
        // Out-of-range coords park on address 0 so the RAM index never leaves the array.
        addr_d = '0;
        if (in_range_d) begin
            addr_d = ADDR_W'(32'(row_i) * BIN_H + 32'(col_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            valid_q    <= valid_i;
            in_range_q <= in_range_d;
            addr_q     <= addr_d;
        end
    end

    assign valid_o    = valid_q;
    assign in_range_o = in_range_q;
    assign addr_o     = addr_q;
endmodule

// File: rtl/unbinning_2.sv
// 4x4 nearest-neighbour upsampler: coarse mask frame buffer replayed at full resolution, 3-cycle
// read latency. UNBINNING_DOUBLE_BUFFER_EN selects ping-pong banks swapped at read frame start.
module unbinning_2
    import unbinning_2_pkg::*;
#(
    parameter int unsigned HRES        = 1280,
    parameter int unsigned VRES        = 720,
    parameter int unsigned DATA_WIDTH  = 1,
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic          clk_in,
    input  logic          rst_in,
    unbinning_2_if.slave  bus
);
    localparam int unsigned SHIFT  = $clog2(KERNEL_SIZE);
    localparam int unsigned BIN_H  = bin_dim(HRES, KERNEL_SIZE);
    localparam int unsigned BIN_V  = bin_dim(VRES, KERNEL_SIZE);
    localparam int unsigned HWIDTH = count_width(HRES);
    localparam int unsigned VWIDTH = count_width(VRES);
    localparam int unsigned ADDR_W = addr_width(HRES, VRES, KERNEL_SIZE);
`ifdef UNBINNING_DOUBLE_BUFFER_EN
    localparam int unsigned RAM_AW    = ADDR_W + 1;
    localparam int unsigned RAM_DEPTH = 2 << ADDR_W;
`else
    localparam int unsigned RAM_AW    = ADDR_W;
    localparam int unsigned RAM_DEPTH = BIN_H * BIN_V;
`endif

    logic                  wr_valid, wr_in_range, rd_valid, rd_in_range, last_px;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [RAM_AW-1:0]     ram_wr_addr, ram_rd_addr;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] wr_data_q, ram_rd_q, pixel_q;
    logic [HWIDTH-1:0]     hcount_s1_q, hcount_s2_q, hcount_q;
    logic [VWIDTH-1:0]     vcount_s1_q, vcount_s2_q, vcount_q;
    logic                  rd_valid_s2_q, rd_range_s2_q, data_valid_q, frame_ready_q;

    assign last_px = bus.bin_valid_in && (32'(bus.bin_hcount_in) == BIN_H - 1)
                     && (32'(bus.bin_vcount_in) == BIN_V - 1);

    unbin_addr_gen #(
        .ROW_W (VWIDTH - SHIFT), .COL_W (HWIDTH - SHIFT),
        .BIN_H (BIN_H), .BIN_V (BIN_V), .ADDR_W (ADDR_W)
    ) u_wr_addr (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .valid_i    (bus.bin_valid_in),
        .row_i      (bus.bin_vcount_in),
        .col_i      (bus.bin_hcount_in),
        .valid_o    (wr_valid),
        .in_range_o (wr_in_range),
        .addr_o     (wr_addr)
    );

    unbin_addr_gen #(
        .ROW_W (VWIDTH - SHIFT), .COL_W (HWIDTH - SHIFT),
        .BIN_H (BIN_H), .BIN_V (BIN_V), .ADDR_W (ADDR_W)
    ) u_rd_addr (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .valid_i    (bus.read_valid_in),
        .row_i      (bus.vcount_in[VWIDTH-1:SHIFT]),
        .col_i      (bus.hcount_in[HWIDTH-1:SHIFT]),
        .valid_o    (rd_valid),
        .in_range_o (rd_in_range),
        .addr_o     (rd_addr)
    );

`ifdef UNBINNING_DOUBLE_BUFFER_EN
    logic rd_bank_q, rd_bank_d, swap_pending_q, swap_pending_d, wr_bank_q, rd_sel_q, swap;

    always_comb begin
        swap = swap_pending_q && bus.read_valid_in && (bus.hcount_in == '0)
               && (bus.vcount_in == '0);
        rd_bank_d = rd_bank_q ^ swap;
        // A frame completing on the swap cycle re-arms the swap for the next frame start.
        swap_pending_d = last_px || (swap_pending_q && !swap);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_bank_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_bank_q      <= 1'b0;
            rd_sel_q       <= 1'b0;
        end else begin
            rd_bank_q      <= rd_bank_d;
            swap_pending_q <= swap_pending_d;
            wr_bank_q      <= ~rd_bank_q;
            rd_sel_q       <= rd_bank_d;
        end
    end

    assign ram_wr_addr = {wr_bank_q, wr_addr};
    assign ram_rd_addr = {rd_sel_q, rd_addr};
`else
    assign ram_wr_addr = wr_addr;
    assign ram_rd_addr = rd_addr;
`endif

    // Read-first: a same-edge write to the read address is not visible to that read.
    always_ff @(posedge clk_in) begin
        if (wr_valid && wr_in_range) begin
            mem[ram_wr_addr] <= wr_data_q;
        end
        ram_rd_q <= mem[ram_rd_addr];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_data_q     <= '0;
            hcount_s1_q   <= '0;
            vcount_s1_q   <= '0;
            hcount_s2_q   <= '0;
            vcount_s2_q   <= '0;
            rd_valid_s2_q <= 1'b0;
            rd_range_s2_q <= 1'b0;
            pixel_q       <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            data_valid_q  <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            wr_data_q     <= bus.bin_pixel_in;
            hcount_s1_q   <= bus.hcount_in;
            vcount_s1_q   <= bus.vcount_in;
            hcount_s2_q   <= hcount_s1_q;
            vcount_s2_q   <= vcount_s1_q;
            rd_valid_s2_q <= rd_valid;
            rd_range_s2_q <= rd_in_range;
            pixel_q       <= (rd_valid_s2_q && rd_range_s2_q) ? ram_rd_q : '0;
            hcount_q      <= hcount_s2_q;
            vcount_q      <= vcount_s2_q;
            data_valid_q  <= rd_valid_s2_q;
            frame_ready_q <= frame_ready_q | last_px;
        end
    end

    assign bus.pixel_data_out  = pixel_q;
    assign bus.hcount_out      = hcount_q;
    assign bus.vcount_out      = vcount_q;
    assign bus.data_valid_out  = data_valid_q;
    assign bus.frame_ready_out = frame_ready_q;
endmodule

// File: tb/tb_unbinning_2.sv
// Bench for unbinning_2 at 16x8 (coarse 4x2): frame-level model plus directed literal checks.
module tb_unbinning_2;
`ifdef UNBINNING_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    typedef struct {
        bit valid;
        bit known;
        int pix;
        int h;
        int v;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Model state: coarse frame per bank (-1 = never written), display bank, pending swap.
    int   cm [2][2][4];
    int   rdb = 0;
    bit   pending = 1'b0;
    bit   model_ready = 1'b0;
    exp_t pipe [3];

    unbinning_2_if #(.HWIDTH(5), .VWIDTH(4), .SHIFT(2), .DATA_WIDTH(1)) bus ();

    unbinning_2 #(.HRES(16), .VRES(8), .DATA_WIDTH(1), .KERNEL_SIZE(4)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{valid: 1'b0, known: 1'b1, pix: 0, h: 0, v: 0};
        rdb         = 0;
        pending     = 1'b0;
        model_ready = 1'b0;
    endfunction

    function automatic void model_step();
        int   hc, vc, bh, bv, wb;
        bit   rv;
        exp_t e;
        hc = int'(bus.hcount_in);
        vc = int'(bus.vcount_in);
        rv = bus.read_valid_in;
        bh = int'(bus.bin_hcount_in);
        bv = int'(bus.bin_vcount_in);
        wb = DB ? 1 - rdb : 0;
        if (DB && pending && rv && hc == 0 && vc == 0) begin
            rdb     = 1 - rdb;
            pending = 1'b0;
        end
        e = '{valid: rv, known: 1'b1, pix: 0, h: hc, v: vc};
        if (rv && hc < 16 && vc < 8) begin
            if (cm[rdb][vc / 4][hc / 4] < 0) e.known = 1'b0;
            else e.pix = cm[rdb][vc / 4][hc / 4];
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        // Reads above saw memory before this edge's write.
        if (bus.bin_valid_in && bh < 4 && bv < 2) begin
            cm[wb][bv][bh] = int'(bus.bin_pixel_in);
            if (bh == 3 && bv == 1) begin
                model_ready = 1'b1;
                if (DB) pending = 1'b1;
            end
        end
    endfunction

    initial begin : model_proc
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 4; c++) cm[b][r][c] = -1;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            chk("data_valid", int'(bus.data_valid_out), int'(pipe[2].valid));
            chk("frame_ready", int'(bus.frame_ready_out), int'(model_ready));
            if (pipe[2].valid) begin
                chk("hcount_out", int'(bus.hcount_out), pipe[2].h);
                chk("vcount_out", int'(bus.vcount_out), pipe[2].v);
                if (pipe[2].known) chk("pixel", int'(bus.pixel_data_out), pipe[2].pix);
            end else begin
                chk("pixel_idle", int'(bus.pixel_data_out), 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int h, input int v, input int p);
        bus.bin_valid_in  = 1'b1;
        bus.bin_hcount_in = 3'(h);
        bus.bin_vcount_in = 2'(v);
        bus.bin_pixel_in  = 1'(p);
        if (h == 3 && v == 1 && !model_ready) begin
            @(negedge clk);
            chk("ready_before_last", int'(bus.frame_ready_out), 0);
            step();
            chk("ready_after_last", int'(bus.frame_ready_out), 1);
        end else begin
            step();
        end
        bus.bin_valid_in = 1'b0;
    endtask

    // pat: 0 checkerboard h^v, 1 inverted checkerboard, 2 all ones, 3 all zeros
    task automatic write_frame(input int pat);
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 4; h++)
                write_px(h, v, pat == 0 ? (h ^ v) & 1 : pat == 1 ? ((h ^ v) & 1) ^ 1 : pat == 2 ? 1 : 0);
    endtask

    // One read pulse; exp_pix < 0 skips the literal pixel check. Optional same-cycle write.
    task automatic read_one(input int h, input int v, input int exp_pix, input bit wr,
                            input int wh, input int wv, input int wp);
        bus.read_valid_in = 1'b1;
        bus.hcount_in     = 5'(h);
        bus.vcount_in     = 4'(v);
        bus.bin_valid_in  = wr;
        bus.bin_hcount_in = 3'(wh);
        bus.bin_vcount_in = 2'(wv);
        bus.bin_pixel_in  = 1'(wp);
        step();
        bus.read_valid_in = 1'b0;
        bus.bin_valid_in  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_not_yet", int'(bus.data_valid_out), 0);
        @(negedge clk);
        chk("lat_valid", int'(bus.data_valid_out), 1);
        chk("lat_hcount", int'(bus.hcount_out), h);
        chk("lat_vcount", int'(bus.vcount_out), v);
        if (exp_pix >= 0) chk("lit_pixel", int'(bus.pixel_data_out), exp_pix);
        step();
    endtask

    task automatic raster_read();
        for (int v = 0; v < 8; v++)
            for (int h = 0; h < 16; h++) begin
                bus.read_valid_in = 1'b1;
                bus.hcount_in     = 5'(h);
                bus.vcount_in     = 4'(v);
                step();
            end
        bus.read_valid_in = 1'b0;
        repeat (3) step();
    endtask

    initial begin : stimulus
        bus.bin_valid_in  = 1'b0;
        bus.bin_hcount_in = '0;
        bus.bin_vcount_in = '0;
        bus.bin_pixel_in  = '0;
        bus.read_valid_in = 1'b0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        @(negedge clk);
        chk("rst_data_valid", int'(bus.data_valid_out), 0);
        chk("rst_frame_ready", int'(bus.frame_ready_out), 0);
        chk("rst_pixel", int'(bus.pixel_data_out), 0);
        chk("rst_hcount", int'(bus.hcount_out), 0);
        step();
        rst_n = 1'b1;
        step();

`ifdef UNBINNING_DOUBLE_BUFFER_EN
        write_frame(2);
        read_one(4, 0, -1, 1'b0, 0, 0, 0);
        read_one(0, 0, 1, 1'b0, 0, 0, 0);
        read_one(12, 4, 1, 1'b0, 0, 0, 0);
        write_frame(3);
        read_one(4, 4, 1, 1'b0, 0, 0, 0);
        read_one(0, 0, 0, 1'b0, 0, 0, 0);
        raster_read();
`else
        write_frame(0);
        raster_read();
        read_one(5, 6, 0, 1'b0, 0, 0, 0);
        read_one(4, 0, 1, 1'b0, 0, 0, 0);
        read_one(0, 4, 1, 1'b0, 0, 0, 0);
        read_one(15, 7, 0, 1'b0, 0, 0, 0);
        // Coarse column 4/5 would alias onto row 1 if not dropped.
        write_px(4, 0, 1);
        write_px(5, 0, 1);
        read_one(4, 4, 0, 1'b0, 0, 0, 0);
        read_one(16, 0, 0, 1'b0, 0, 0, 0);
        read_one(0, 8, 0, 1'b0, 0, 0, 0);
        write_frame(1);
        chk("ready_sticky", int'(bus.frame_ready_out), 1);
        read_one(5, 6, 1, 1'b0, 0, 0, 0);
        read_one(8, 0, 1, 1'b1, 2, 0, 0);
        read_one(8, 3, 0, 1'b0, 0, 0, 0);
        raster_read();
        for (int i = 0; i < 6; i++) begin
            bus.read_valid_in = 1'b1;
            bus.hcount_in     = 5'(i);
            bus.vcount_in     = 4'd1;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.data_valid_out), 0);
        chk("async_rst_ready", int'(bus.frame_ready_out), 0);
        bus.read_valid_in = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        read_one(4, 0, 0, 1'b0, 0, 0, 0);
`endif
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
